mux2_result_fifo: RTL and testbench

- Downstream buffering stage for the 6-bit result `y` of the two-level logic mux.
- Captures each valid result word and holds it in a small first-word-fall-through (FWFT) FIFO.
- Presents stored words to the consumer with a valid/ready handshake.
- Decouples mux evaluation rate from consumer back-pressure; also reports occupancy.

---
 rtl/mux2_result_fifo.sv | 126 ++++++++++++
 tb/tb_mux2_result_fifo.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/mux2_result_fifo.sv
// mux2_result_fifo: first-word-fall-through buffer for the 6-bit mux result.
// Captures each valid result word and presents the head word to the consumer
// through a valid/ready handshake. Occupancy is reported as count/full/empty.
// Optional feature macro: MUX2_RESULT_FIFO_STATS_EN adds max_count (high-water
// mark) and stall_cnt (saturating back-pressure cycle counter).
//
// Occupancy states are implicit in count:
//   state   | meaning
//   EMPTY   | count == 0, out_valid low
//   PARTIAL | 0 < count < DEPTH, both sides may move
//   FULL    | count == DEPTH, in_ready low unless flushing
module mux2_result_fifo #(
   parameter int DATA_W = 6,
   parameter int DEPTH  = 8,
   parameter int ADDR_W = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_valid,
   output logic              in_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              out_valid,
   input  logic              out_ready,
   input  logic              flush,
   output logic [ADDR_W:0]   count,
   output logic              full,
   output logic              empty
`ifdef MUX2_RESULT_FIFO_STATS_EN
   ,
   output logic [ADDR_W:0]   max_count,
   output logic [7:0]        stall_cnt
`endif
);

   localparam logic [ADDR_W:0]   FULL_CNT = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);
   localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [ADDR_W:0]   count_q, count_d;
   logic              push, pop;

   // Handshake and status decode; a flush cycle never back-pressures the producer.
   always_comb begin
      full      = (count_q == FULL_CNT);
      empty     = (count_q == '0);
      in_ready  = !full || flush;
      out_valid = !empty;
      out_data  = mem_q[rd_ptr_q];
      count     = count_q;
      push      = in_valid && in_ready && !flush;
      pop       = out_valid && out_ready && !flush;
   end

   // Next pointer and occupancy; flush discards any transfer in its cycle.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
         if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
         if (push && !pop)      count_d = count_q + CNT_ONE;
         else if (pop && !push) count_d = count_q - CNT_ONE;
      end
   end

   // Pointer and occupancy registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage array; contents are not cleared by reset or flush.
   always_ff @(posedge clk) begin
      if (push && !rst) mem_q[wr_ptr_q] <= in_data;
   end

`ifdef MUX2_RESULT_FIFO_STATS_EN
   logic [ADDR_W:0] max_count_q, max_count_d;
   logic [7:0]      stall_cnt_q, stall_cnt_d;

   // High-water mark follows count one cycle later; stall counter saturates.
   always_comb begin
      max_count_d = max_count_q;
      stall_cnt_d = stall_cnt_q;
      if (flush) begin
         max_count_d = '0;
         stall_cnt_d = '0;
      end else begin
         if (count_q > max_count_q) max_count_d = count_q;
         if (in_valid && !in_ready && (stall_cnt_q != 8'hFF))
            stall_cnt_d = stall_cnt_q + 8'd1;
      end
   end

   // Statistics registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         max_count_q <= '0;
         stall_cnt_q <= '0;
      end else begin
         max_count_q <= max_count_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign max_count = max_count_q;
   assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_mux2_result_fifo.sv
// Bench for mux2_result_fifo: directed steps from the test plan followed by
// random traffic, all checked against a queue-based reference model.
module tb_mux2_result_fifo;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [5:0] in_data = '0;
   logic       in_valid = 1'b0;
   logic       in_ready;
   logic [5:0] out_data;
   logic       out_valid;
   logic       out_ready = 1'b0;
   logic       flush = 1'b0;
   logic [3:0] count;
   logic       full;
   logic       empty;
`ifdef MUX2_RESULT_FIFO_STATS_EN
   logic [3:0] max_count;
   logic [7:0] stall_cnt;
`endif

   mux2_result_fifo dut (
      .clk       (clk),
      .rst       (rst),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .flush     (flush),
      .count     (count),
      .full      (full),
      .empty     (empty)
`ifdef MUX2_RESULT_FIFO_STATS_EN
      ,
      .max_count (max_count),
      .stall_cnt (stall_cnt)
`endif
   );

   always #5 clk = ~clk;

   int vectors = 0;
   int miscompares = 0;

   logic [5:0] q_m [$];
   bit         known_m = 0;
   int         max_m = 0;
   int         stall_m = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp)
      else begin
         miscompares++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // One clock cycle: drive inputs, check outputs against the model, advance model.
   task automatic step(input logic iv, input logic [5:0] d, input logic ordy,
                       input logic fl, input logic r);
      int  sz;
      bit  rdy_m, vld_m;
      @(negedge clk);
      in_valid  = iv;
      in_data   = d;
      out_ready = ordy;
      flush     = fl;
      rst       = r;
      #1;
      sz    = q_m.size();
      rdy_m = (sz < 8) || fl;
      vld_m = (sz > 0);
      if (known_m) begin
         chk("count", 32'(count), 32'(sz));
         chk("empty", 32'(empty), 32'(sz == 0));
         chk("full", 32'(full), 32'(sz == 8));
         chk("in_ready", 32'(in_ready), 32'(rdy_m));
         chk("out_valid", 32'(out_valid), 32'(vld_m));
         if (vld_m) chk("out_data", 32'(out_data), 32'(q_m[0]));
`ifdef MUX2_RESULT_FIFO_STATS_EN
         chk("max_count", 32'(max_count), 32'(max_m));
         chk("stall_cnt", 32'(stall_cnt), 32'(stall_m));
`endif
      end
      if (r || fl) begin
         q_m.delete();
         max_m   = 0;
         stall_m = 0;
         if (r) known_m = 1;
      end else begin
         if (sz > max_m) max_m = sz;
         if (iv && !rdy_m && stall_m < 255) stall_m++;
         if (vld_m && ordy) void'(q_m.pop_front());
         if (iv && rdy_m) q_m.push_back(d);
      end
      @(posedge clk);
   endtask

   initial begin
      // Reset then idle
      step(0, 0, 0, 0, 1);
      step(0, 0, 0, 0, 1);
      step(0, 0, 0, 0, 0);
      chk("idle_empty", 32'(empty), 32'd1);

      // Single word with one-cycle latency
      step(1, 6'd37, 0, 0, 0);
      step(0, 0, 0, 0, 0);
      chk("single_data", 32'(out_data), 32'd37);
      step(0, 0, 1, 0, 0);
      step(0, 0, 0, 0, 0);

      // Fill, overflow attempt, drain in order
      for (int i = 1; i <= 8; i++) step(1, 6'(i), 0, 0, 0);
      step(1, 6'd9, 0, 0, 0);
      chk("full_ready", 32'(in_ready), 32'd0);
      step(1, 6'd9, 0, 0, 0);
      for (int i = 0; i < 9; i++) step(0, 0, 1, 0, 0);

      // Wrap-around with concurrent push and pop
      for (int i = 1; i <= 5; i++) step(1, 6'(40 + i), 0, 0, 0);
      for (int i = 10; i <= 21; i++) step(1, 6'(i), 1, 0, 0);
      step(0, 0, 0, 0, 0);
      chk("wrap_count", 32'(count), 32'd5);

      // Flush priority, then reset mid-stream
      step(0, 0, 1, 0, 0);
      step(1, 6'd50, 1, 1, 0);
      step(0, 0, 1, 0, 0);
      step(0, 0, 1, 0, 0);
      for (int i = 0; i < 6; i++) step(1, 6'(20 + i), 0, 0, 0);
      step(1, 6'd33, 1, 0, 1);
      step(0, 0, 0, 0, 0);

      // Statistics scenario (also exercises plain FIFO behaviour)
      for (int i = 0; i < 6; i++) step(1, 6'(i), 0, 0, 0);
      for (int i = 0; i < 4; i++) step(0, 0, 1, 0, 0);
      for (int i = 0; i < 6; i++) step(1, 6'(30 + i), 0, 0, 0);
      for (int i = 0; i < 3; i++) step(1, 6'd63, 0, 0, 0);
      step(0, 0, 0, 0, 0);
      step(0, 0, 0, 1, 0);
      step(0, 0, 0, 0, 0);

      // Random traffic
      for (int i = 0; i < 600; i++) begin
         step(1'($urandom_range(0, 3) != 0), 6'($urandom),
              1'($urandom_range(0, 2) == 0),
              1'($urandom_range(0, 59) == 0),
              1'($urandom_range(0, 149) == 0));
      end
      step(0, 0, 0, 0, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
